multi_channel_lfsr_cipher: RTL

//  N_CH-channel XOR stream cipher with a W-bit-per-beat datapath. Each channel keeps its own

---
 rtl/multi_channel_lfsr_cipher_if.sv | 25 ++
 rtl/multi_channel_lfsr_cipher.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_lfsr_cipher_if.sv
// Tagged valid/ready stream bundle for the multi-channel LFSR cipher.
// The cipher is the slave; the traffic source/sink is the master.
interface multi_channel_lfsr_cipher_if #(
  parameter int CHW = 1,
  parameter int W   = 8
);
  logic           s_valid;
  logic           s_ready;
  logic [CHW-1:0] s_ch;
  logic [W-1:0]   s_data;
  logic           m_valid;
  logic           m_ready;
  logic [CHW-1:0] m_ch;
  logic [W-1:0]   m_data;

  modport slave (
    input  s_valid, s_ch, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_data
  );

  modport master (
    output s_valid, s_ch, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_data
  );
endinterface

// File: rtl/multi_channel_lfsr_cipher.sv
// N_CH-channel Galois-LFSR XOR stream cipher on a tagged valid/ready stream, with
// per-channel taps/seeds loaded through a bit-count-checked serial config chain.
//
// state    | meaning
// ST_RUN   | streaming; cfg_en high starts a config frame
// ST_SHIFT | config frame shifting into the shadow chain
// ST_LOAD  | one cycle: shadow chain copied into working taps/states/bypass
module multi_channel_lfsr_cipher #(
  parameter int            N_CH         = 2,
  parameter int            M            = 32,
  parameter int            W            = 8,
  parameter logic [M-1:0]  TAPS_DEFAULT = 32'h48000000,
  parameter logic [M-1:0]  SEED_DEFAULT = 32'h00000055,
  localparam int           CHW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multi_channel_lfsr_cipher_if.slave bus,
  input  logic                      cfg_en,
  input  logic                      cfg_i,
  output logic                      cfg_o,
  output logic                      cfg_err,
  output logic [N_CH-1:0]           lockup
);

  localparam int L    = 2 * M * N_CH + 1;
  localparam int CNTW = $clog2(L + 2);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(L);
  localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(L + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  function automatic logic [L-1:0] reset_chain();
    logic [L-1:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      r[2*M*c +: M]     = SEED_DEFAULT;
      r[2*M*c + M +: M] = TAPS_DEFAULT;
    end
    return r;
  endfunction

  localparam logic [L-1:0] CHAIN_RST = reset_chain();

  logic [1:0]      fsm_q, fsm_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [L-1:0]    chain_q, chain_d;
  logic            cfg_err_q, cfg_err_d;
  logic            bypass_q, bypass_d;
  logic [M-1:0]    taps_q [N_CH];
  logic [M-1:0]    taps_d [N_CH];
  logic [M-1:0]    state_q [N_CH];
  logic [M-1:0]    state_d [N_CH];
  logic            m_valid_q, m_valid_d;
  logic [CHW-1:0]  m_ch_q, m_ch_d;
  logic [W-1:0]    m_data_q, m_data_d;

  logic            shift_en;
  logic            accept;
  logic            ch_ok;
  logic [CHW-1:0]  ch_idx;
  logic [W-1:0]    ks;
  logic [M-1:0]    st_adv;

  // Tags that cannot reach N_CH need no range check.
  if ((1 << CHW) == N_CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (bus.s_ch < CHW'(N_CH));
  end

  assign ch_idx      = ch_ok ? bus.s_ch : '0;
  assign shift_en    = cfg_en && ((fsm_q == ST_RUN) || (fsm_q == ST_SHIFT));
  assign bus.s_ready = (fsm_q == ST_RUN) && !cfg_en && (!m_valid_q || bus.m_ready);
  assign accept      = bus.s_valid && bus.s_ready;

  assign bus.m_valid = m_valid_q;
  assign bus.m_ch    = m_ch_q;
  assign bus.m_data  = m_data_q;
  assign cfg_o       = shift_en ? chain_q[0] : 1'b0;
  assign cfg_err     = cfg_err_q;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      lockup[c] = (state_q[c] == '0);
    end
  end

  // W Galois steps on the tagged channel; k[i] is bit0 before step i.
  always_comb begin
    ks     = '0;
    st_adv = state_q[ch_idx];
    for (int i = 0; i < W; i++) begin
      ks[i]  = st_adv[0];
      st_adv = st_adv[0] ? ((st_adv >> 1) ^ taps_q[ch_idx]) : (st_adv >> 1);
    end
    if (!ch_ok) begin
      ks = '0;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    chain_d   = chain_q;
    cfg_err_d = cfg_err_q;
    bypass_d  = bypass_q;
    taps_d    = taps_q;
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_ch_d    = m_ch_q;
    m_data_d  = m_data_q;

    if (shift_en) begin
      chain_d = {cfg_i, chain_q[L-1:1]};
    end

    case (fsm_q)
      ST_RUN: begin
        if (cfg_en) begin
          fsm_d = ST_SHIFT;
          cnt_d = CNTW'(1);
        end
      end
      ST_SHIFT: begin
        if (cfg_en) begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == CNT_FULL) begin
          fsm_d = ST_LOAD;
        end else begin
          fsm_d     = ST_RUN;
          cfg_err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        for (int c = 0; c < N_CH; c++) begin
          taps_d[c]  = chain_q[2*M*c + M +: M];
          state_d[c] = chain_q[2*M*c +: M];
        end
        bypass_d  = chain_q[L-1];
        cfg_err_d = 1'b0;
        fsm_d     = ST_RUN;
      end
      default: fsm_d = ST_RUN;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_ch_d    = bus.s_ch;
      m_data_d  = bypass_q ? bus.s_data : (bus.s_data ^ ks);
      if (ch_ok) begin
        state_d[ch_idx] = st_adv;
      end
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q     <= ST_RUN;
      cnt_q     <= '0;
      chain_q   <= CHAIN_RST;
      cfg_err_q <= 1'b0;
      bypass_q  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        taps_q[c]  <= TAPS_DEFAULT;
        state_q[c] <= SEED_DEFAULT;
      end
      m_valid_q <= 1'b0;
      m_ch_q    <= '0;
      m_data_q  <= '0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      chain_q   <= chain_d;
      cfg_err_q <= cfg_err_d;
      bypass_q  <= bypass_d;
      taps_q    <= taps_d;
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_ch_q    <= m_ch_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule
